// File: rtl/puf_link_pkg.sv
// ---------------------------------------------------------------------------
// puf_link_pkg
// Shared types and helpers for the PUF serial frame link.
//   rx_state_e : challenge deserialiser states (RX_SHIFT collects beats,
//                RX_HOLD presents the assembled word until the core takes it)
//   tx_state_e : response serialiser states (TX_IDLE waits for a frame,
//                TX_SEND streams it out beat by beat)
//   OP_NORM / OP_DEBUG : encodings of the operating-mode input
//   beats()    : ceiling division, number of lane beats covering len bits
// ---------------------------------------------------------------------------
package puf_link_pkg;

  typedef enum logic {
    RX_SHIFT = 1'b0,
    RX_HOLD  = 1'b1
  } rx_state_e;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

  localparam logic OP_NORM  = 1'b0;
  localparam logic OP_DEBUG = 1'b1;

  function automatic int beats(input int len, input int lane);
    return (len + lane - 1) / lane;
  endfunction

endpackage

// File: rtl/puf_frame_serializer.sv
// ---------------------------------------------------------------------------
// puf_frame_serializer
// Loads a PUF response frame and streams it to the host LSB-first, LANE_W
// bits per beat, with valid/ready backpressure and a last-beat flag.
// Ports:
//   clk, rst_n      clock / asynchronous active-low reset
//   i_op_mode       frame length select, sampled only when a frame loads
//   i_resp_data     response frame (normal mode uses [NORM_MOD-1:0])
//   i_resp_valid    frame valid
//   o_resp_ready    serialiser idle and able to load a frame
//   o_tx_data       current beat (zero outside TX_SEND)
//   o_tx_valid      beat valid
//   o_tx_last       current beat is the final beat of the frame
//   i_tx_ready      host accepts the beat
// ---------------------------------------------------------------------------
module puf_frame_serializer
  import puf_link_pkg::*;
#(
  parameter int LANE_W    = 1,
  parameter int NORM_MOD  = 34,
  parameter int DEBUG_MOD = 133
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_op_mode,
  input  logic [DEBUG_MOD-1:0] i_resp_data,
  input  logic                 i_resp_valid,
  output logic                 o_resp_ready,
  output logic [LANE_W-1:0]    o_tx_data,
  output logic                 o_tx_valid,
  output logic                 o_tx_last,
  input  logic                 i_tx_ready
);

  localparam int MAX_BEATS  = beats(DEBUG_MOD, LANE_W);
  localparam int NORM_BEATS = beats(NORM_MOD, LANE_W);
  // Frame register rounded up to whole beats so the final partial beat
  // shifts in zeros from above.
  localparam int FRAME_W    = MAX_BEATS * LANE_W;
  localparam int CNT_W      = $clog2(MAX_BEATS + 1);

  tx_state_e          state_q;
  logic [FRAME_W-1:0] frame_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   last_idx_q;
  logic               valid_q;
  logic               resp_ready_q;

  logic [FRAME_W-1:0] load_frame_d;
  logic               keep_upper_d;

  // In normal mode bits at and above NORM_MOD are masked at load time, so a
  // partial last beat is zero-padded regardless of what the core drives there.
  assign keep_upper_d = (i_op_mode == OP_DEBUG);

  for (genvar gi = 0; gi < FRAME_W; gi++) begin : g_load
    if (gi < NORM_MOD) begin : g_norm
      assign load_frame_d[gi] = i_resp_data[gi];
    end else if (gi < DEBUG_MOD) begin : g_dbg
      assign load_frame_d[gi] = i_resp_data[gi] & keep_upper_d;
    end else begin : g_pad
      assign load_frame_d[gi] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= TX_IDLE;
      frame_q      <= '0;
      cnt_q        <= '0;
      last_idx_q   <= '0;
      valid_q      <= 1'b0;
      resp_ready_q <= 1'b0;
    end else begin
      case (state_q)
        TX_IDLE: begin
          resp_ready_q <= 1'b1;
          if (i_resp_valid && resp_ready_q) begin
            frame_q      <= load_frame_d;
            cnt_q        <= '0;
            // Length is latched here; later mode changes do not affect the frame.
            last_idx_q   <= (i_op_mode == OP_DEBUG) ? CNT_W'(MAX_BEATS - 1)
                                                    : CNT_W'(NORM_BEATS - 1);
            valid_q      <= 1'b1;
            resp_ready_q <= 1'b0;
            state_q      <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (i_tx_ready) begin
            frame_q <= frame_q >> LANE_W;
            if (cnt_q == last_idx_q) begin
              cnt_q        <= '0;
              valid_q      <= 1'b0;
              resp_ready_q <= 1'b1;
              state_q      <= TX_IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  assign o_resp_ready = resp_ready_q;
  assign o_tx_valid   = valid_q;
  assign o_tx_data    = valid_q ? frame_q[LANE_W-1:0] : '0;
  assign o_tx_last    = valid_q && (cnt_q == last_idx_q);

endmodule

// File: rtl/puf_serial_frame_link.sv
// ---------------------------------------------------------------------------
// puf_serial_frame_link
// Host-side serial link of the PUF SoC. Assembles challenge words from a
// LANE_W-bit valid/ready beat stream and streams response frames back.
// Ports:
//   clk, rst_n                  clock / asynchronous active-low reset
//   i_op_mode                   0 normal (NORM_MOD bits), 1 debug (DEBUG_MOD)
//   i_rx_valid/i_rx_data        host challenge beats, o_rx_ready accepts
//   o_chal_data/o_chal_valid    assembled challenge, held until i_chal_ready
//   i_resp_data/i_resp_valid    response frame from the core, o_resp_ready
//   o_tx_data/o_tx_valid/o_tx_last, i_tx_ready   response beats to the host
// RX and TX run independently of each other.
// ---------------------------------------------------------------------------
module puf_serial_frame_link
  import puf_link_pkg::*;
#(
  parameter int LANE_W    = 1,
  parameter int CHAL_W    = 8,
  parameter int NORM_MOD  = 34,
  parameter int DEBUG_MOD = 133
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_op_mode,
  output logic                 o_rx_ready,
  input  logic                 i_rx_valid,
  input  logic [LANE_W-1:0]    i_rx_data,
  output logic [CHAL_W-1:0]    o_chal_data,
  output logic                 o_chal_valid,
  input  logic                 i_chal_ready,
  input  logic [DEBUG_MOD-1:0] i_resp_data,
  input  logic                 i_resp_valid,
  output logic                 o_resp_ready,
  output logic [LANE_W-1:0]    o_tx_data,
  output logic                 o_tx_valid,
  output logic                 o_tx_last,
  input  logic                 i_tx_ready
);

  localparam int CHAL_BEATS = beats(CHAL_W, LANE_W);
  localparam int BUF_W      = CHAL_BEATS * LANE_W;
  localparam int RX_CNT_W   = $clog2(CHAL_BEATS + 1);

  // ---------------- RX: challenge deserialiser ----------------
  rx_state_e           rx_state_q;
  logic [RX_CNT_W-1:0] rx_cnt_q;
  logic [BUF_W-1:0]    chal_buf_q;
  logic [BUF_W-1:0]    chal_buf_d;
  logic                rx_ready_q;
  logic                chal_valid_q;
  logic                rx_fire;
  logic                rx_last_beat;

  assign rx_fire      = i_rx_valid && rx_ready_q;
  assign rx_last_beat = (rx_cnt_q == RX_CNT_W'(CHAL_BEATS - 1));

  // Beat k lands in its own lane slot; the counter only advances on a
  // transfer, so gaps in i_rx_valid simply leave the buffer untouched.
  for (genvar gi = 0; gi < CHAL_BEATS; gi++) begin : g_rx_lane
    assign chal_buf_d[gi*LANE_W +: LANE_W] =
      (rx_fire && (rx_cnt_q == RX_CNT_W'(gi))) ? i_rx_data
                                               : chal_buf_q[gi*LANE_W +: LANE_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q   <= RX_SHIFT;
      rx_cnt_q     <= '0;
      chal_buf_q   <= '0;
      rx_ready_q   <= 1'b0;
      chal_valid_q <= 1'b0;
    end else begin
      chal_buf_q <= chal_buf_d;
      case (rx_state_q)
        RX_SHIFT: begin
          rx_ready_q <= 1'b1;
          if (rx_fire) begin
            if (rx_last_beat) begin
              rx_cnt_q     <= '0;
              rx_ready_q   <= 1'b0;
              chal_valid_q <= 1'b1;
              rx_state_q   <= RX_HOLD;
            end else begin
              rx_cnt_q <= rx_cnt_q + 1'b1;
            end
          end
        end
        RX_HOLD: begin
          if (i_chal_ready) begin
            chal_valid_q <= 1'b0;
            rx_ready_q   <= 1'b1;
            rx_state_q   <= RX_SHIFT;
          end
        end
        default: rx_state_q <= RX_SHIFT;
      endcase
    end
  end

  assign o_rx_ready   = rx_ready_q;
  assign o_chal_valid = chal_valid_q;
  // Lane padding above CHAL_W is never presented.
  assign o_chal_data  = chal_buf_q[CHAL_W-1:0];

  // ---------------- TX: response serialiser ----------------
  puf_frame_serializer #(
    .LANE_W    (LANE_W),
    .NORM_MOD  (NORM_MOD),
    .DEBUG_MOD (DEBUG_MOD)
  ) u_serializer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_op_mode    (i_op_mode),
    .i_resp_data  (i_resp_data),
    .i_resp_valid (i_resp_valid),
    .o_resp_ready (o_resp_ready),
    .o_tx_data    (o_tx_data),
    .o_tx_valid   (o_tx_valid),
    .o_tx_last    (o_tx_last),
    .i_tx_ready   (i_tx_ready)
  );

endmodule

// File: tb/tb_puf_serial_frame_link.sv
module tb_puf_serial_frame_link;
  import puf_link_pkg::*;

  localparam int NM = 34;
  localparam int DM = 133;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // LANE_W = 1 instance
  logic          op_mode, rx_valid, chal_ready, resp_valid, tx_ready;
  logic [0:0]    rx_data, tx_data;
  logic          rx_ready, chal_valid, resp_ready, tx_valid, tx_last;
  logic [7:0]    chal_data;
  logic [DM-1:0] resp_data;

  // LANE_W = 4 instance
  logic          op_mode4, rx_valid4, chal_ready4, resp_valid4, tx_ready4;
  logic [3:0]    rx_data4, tx_data4;
  logic          rx_ready4, chal_valid4, resp_ready4, tx_valid4, tx_last4;
  logic [7:0]    chal_data4;
  logic [DM-1:0] resp_data4;

  puf_serial_frame_link #(.LANE_W(1), .CHAL_W(8), .NORM_MOD(NM), .DEBUG_MOD(DM)) dut (
    .clk(clk), .rst_n(rst_n), .i_op_mode(op_mode),
    .o_rx_ready(rx_ready), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
    .o_chal_data(chal_data), .o_chal_valid(chal_valid), .i_chal_ready(chal_ready),
    .i_resp_data(resp_data), .i_resp_valid(resp_valid), .o_resp_ready(resp_ready),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .o_tx_last(tx_last), .i_tx_ready(tx_ready)
  );

  puf_serial_frame_link #(.LANE_W(4), .CHAL_W(8), .NORM_MOD(NM), .DEBUG_MOD(DM)) dut4 (
    .clk(clk), .rst_n(rst_n), .i_op_mode(op_mode4),
    .o_rx_ready(rx_ready4), .i_rx_valid(rx_valid4), .i_rx_data(rx_data4),
    .o_chal_data(chal_data4), .o_chal_valid(chal_valid4), .i_chal_ready(chal_ready4),
    .i_resp_data(resp_data4), .i_resp_valid(resp_valid4), .o_resp_ready(resp_ready4),
    .o_tx_data(tx_data4), .o_tx_valid(tx_valid4), .o_tx_last(tx_last4), .i_tx_ready(tx_ready4)
  );

  typedef struct packed {
    logic [3:0] data;
    logic       last;
  } beat_t;

  beat_t      exp_tx1[$];
  beat_t      exp_tx4[$];
  logic [7:0] exp_chal[$];
  logic [7:0] exp_chal4[$];

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int tx_seen1 = 0;
  int tx_seen4 = 0;
  bit toggle_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitors ----------------
  logic  stall_p, stall_last, rr_due, chal_seen;
  logic [0:0] stall_data;
  beat_t e1;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_p   = 1'b0;
      rr_due    = 1'b0;
      chal_seen = 1'b0;
    end else begin
      if (rr_due) begin
        check("resp_ready_after_last", {62'b0, resp_ready, tx_valid}, 64'b10);
        rr_due = 1'b0;
      end
      if (stall_p)
        check("tx_stall_hold", {62'b0, tx_data, tx_last}, {62'b0, stall_data, stall_last});
      stall_p    = tx_valid && !tx_ready;
      stall_data = tx_data;
      stall_last = tx_last;
      if (tx_valid && tx_ready) begin
        if (exp_tx1.size() == 0) check("tx1_unexpected_beat", 64'd1, 64'd0);
        else begin
          e1 = exp_tx1.pop_front();
          check("tx1_beat", {62'b0, tx_data, tx_last}, {62'b0, e1.data[0], e1.last});
          if (e1.last) rr_due = 1'b1;
        end
        tx_seen1++;
      end
      if (chal_valid && !chal_seen) begin
        if (exp_chal.size() == 0) check("chal_unexpected", 64'd1, 64'd0);
        else check("chal_word", {56'b0, chal_data}, {56'b0, exp_chal.pop_front()});
      end
      chal_seen = chal_valid;
    end
  end

  beat_t e4;
  logic  chal_seen4;
  always @(negedge clk) begin
    if (!rst_n) chal_seen4 = 1'b0;
    else begin
      if (tx_valid4 && tx_ready4) begin
        if (exp_tx4.size() == 0) check("tx4_unexpected_beat", 64'd1, 64'd0);
        else begin
          e4 = exp_tx4.pop_front();
          check("tx4_beat", {59'b0, tx_data4, tx_last4}, {59'b0, e4.data, e4.last});
        end
        tx_seen4++;
      end
      if (chal_valid4 && !chal_seen4) begin
        if (exp_chal4.size() == 0) check("chal4_unexpected", 64'd1, 64'd0);
        else check("chal4_word", {56'b0, chal_data4}, {56'b0, exp_chal4.pop_front()});
      end
      chal_seen4 = chal_valid4;
    end
  end

  // ready toggler for the stalled debug frame
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (toggle_en) tx_ready = ~tx_ready;
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic send_bit(input logic b);
    int n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 50) begin tick(); n++; end
    if (n == 50) check("rx_ready_timeout", 64'd0, 64'd1);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_nib(input logic [3:0] v);
    int n = 0;
    rx_valid4 = 1'b1;
    rx_data4  = v;
    while (!rx_ready4 && n < 50) begin tick(); n++; end
    if (n == 50) check("rx4_ready_timeout", 64'd0, 64'd1);
    tick();
    rx_valid4 = 1'b0;
  endtask

  task automatic send_frame1(input logic [DM-1:0] d, input logic mode);
    int n = 0;
    int len;
    op_mode    = mode;
    resp_data  = d;
    resp_valid = 1'b1;
    while (!resp_ready && n < 300) begin tick(); n++; end
    if (n == 300) check("resp_ready_timeout", 64'd0, 64'd1);
    len = mode ? DM : NM;
    for (int b = 0; b < len; b++)
      exp_tx1.push_back('{data: {3'b000, d[b]}, last: (b == len - 1)});
    tick();
    resp_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_tx1.size() != 0 || exp_tx4.size() != 0) && n < budget) begin tick(); n++; end
    check("tx_drain", 64'(exp_tx1.size() + exp_tx4.size()), 64'd0);
    tick();
    tick();
  endtask

  // ---------------- main sequence ----------------
  logic [7:0]    bits;
  logic [DM-1:0] dbg_frame;
  logic [3:0]    nibs [9];
  int            base, n;

  initial begin
    op_mode = 0; rx_valid = 0; rx_data = 0; chal_ready = 0; resp_valid = 0;
    resp_data = '0; tx_ready = 0;
    op_mode4 = 0; rx_valid4 = 0; rx_data4 = 0; chal_ready4 = 0; resp_valid4 = 0;
    resp_data4 = '0; tx_ready4 = 0;
    dbg_frame = {5'h15, 64'hDEAD_BEEF_0123_4567, 64'hFEDC_BA98_7654_3210};

    // 1. reset / idle
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("reset_outputs", {50'b0, rx_ready, resp_ready, chal_valid, chal_data, tx_valid, tx_last, tx_data}, 64'd0);
    check("reset_outputs4", {45'b0, rx_ready4, resp_ready4, chal_valid4, chal_data4, tx_valid4, tx_last4, tx_data4}, 64'd0);
    rst_n = 1'b1;
    tick();
    check("ready_after_reset", {62'b0, rx_ready, resp_ready}, 64'b11);
    check("idle_outputs", {53'b0, chal_valid, chal_data, tx_valid, tx_last, tx_data}, 64'd0);
    check("ready_after_reset4", {62'b0, rx_ready4, resp_ready4}, 64'b11);

    // 2. RX with a 2-cycle gap after bit 3
    exp_chal.push_back(8'h4D);
    bits = 8'b0100_1101;
    for (int i = 0; i < 8; i++) begin
      send_bit(bits[i]);
      if (i == 3) begin tick(); tick(); end
    end
    check("chal_valid_after_bit7", {62'b0, chal_valid, rx_ready}, 64'b10);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rx_hold", {54'b0, rx_ready, chal_valid, chal_data}, {54'b0, 1'b0, 1'b1, 8'h4D});
    end
    chal_ready = 1'b1;
    tick();
    check("rx_release", {62'b0, rx_ready, chal_valid}, 64'b10);
    chal_ready = 1'b0;

    // 3. TX normal frame, no stall
    tx_ready = 1'b1;
    base = tx_seen1;
    send_frame1({99'b0, 34'h2_5A5A_5A5A}, OP_NORM);
    drain(200);
    check("norm_beat_count", 64'(tx_seen1 - base), 64'd34);

    // 4. TX debug frame, toggling ready, mode flipped mid-frame
    base = tx_seen1;
    toggle_en = 1'b1;
    send_frame1(dbg_frame, OP_DEBUG);
    repeat (20) tick();
    op_mode = OP_NORM;
    drain(600);
    toggle_en = 1'b0;
    tx_ready = 1'b1;
    check("debug_beat_count", 64'(tx_seen1 - base), 64'd133);

    // 5. four-lane instance: 9-beat normal frame and 2-beat challenge
    nibs = '{4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h3};
    for (int i = 0; i < 9; i++) exp_tx4.push_back('{data: nibs[i], last: (i == 8)});
    tx_ready4   = 1'b1;
    op_mode4    = OP_NORM;
    resp_data4  = {{99{1'b1}}, 34'h3_1234_5678};
    resp_valid4 = 1'b1;
    tick();
    resp_valid4 = 1'b0;
    base = tx_seen4;
    drain(100);
    check("lane4_beat_count", 64'(tx_seen4 - base), 64'd9);
    exp_chal4.push_back(8'h4D);
    send_nib(4'hD);
    send_nib(4'h4);
    check("lane4_chal_done", {62'b0, chal_valid4, rx_ready4}, 64'b10);
    chal_ready4 = 1'b1;
    tick();
    chal_ready4 = 1'b0;
    check("lane4_rx_release", {62'b0, rx_ready4, chal_valid4}, 64'b10);

    // 6. reset during a debug frame with a partial challenge
    tx_ready = 1'b1;
    base = tx_seen1;
    send_frame1(dbg_frame, OP_DEBUG);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    n = 0;
    while ((tx_seen1 - base) < 17 && n < 100) begin tick(); n++; end
    check("reached_beat17", 64'(tx_seen1 - base), 64'd17);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {50'b0, rx_ready, resp_ready, chal_valid, chal_data, tx_valid, tx_last, tx_data}, 64'd0);
    exp_tx1.delete();
    exp_chal.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("ready_after_rereset", {62'b0, rx_ready, resp_ready}, 64'b11);
    exp_chal.push_back(8'hA5);
    base = tx_seen1;
    send_frame1({99'b0, 34'h1_2345_6789}, OP_NORM);
    bits = 8'hA5;
    for (int i = 0; i < 8; i++) send_bit(bits[i]);
    check("rechal_valid", {62'b0, chal_valid, rx_ready}, 64'b10);
    chal_ready = 1'b1;
    tick();
    chal_ready = 1'b0;
    drain(200);
    check("reframe_beat_count", 64'(tx_seen1 - base), 64'd34);
    check("chal_queue_empty", 64'(exp_chal.size() + exp_chal4.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
